// File: rtl/lt24_frame_scanner.sv
// lt24_frame_scanner
//   Raster pixel source for the LT24 display path. Walks every (x, y) of a
//   frame, produces an RGB565 test pattern for each pixel and hands it to the
//   downstream write driver over a valid/ready handshake. After the last pixel
//   it idles for HOLDOFF cycles before it can start another frame.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-high
//   enable      starts a frame (sampled only in IDLE)
//   patternSel  pattern select, latched at frame start
//   fgColour    foreground RGB565, latched at frame start
//   pixelReady  downstream accepts the current pixel
//   pixelWrite  pixel valid
//   xAddr/yAddr coordinates of the current pixel
//   pixelData   RGB565 for (xAddr, yAddr)
//   frameStart  pulse in the first SCAN cycle
//   frameDone   pulse in the cycle after the last transfer
//   busy        high in SCAN and HOLD
module lt24_frame_scanner #(
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 9,
  parameter int X_MAX      = 239,
  parameter int Y_MAX      = 319,
  parameter int HOLDOFF    = 1000,
  parameter int HOLD_WIDTH = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         patternSel,
  input  logic [15:0]        fgColour,
  input  logic               pixelReady,
  output logic               pixelWrite,
  output logic [X_WIDTH-1:0] xAddr,
  output logic [Y_WIDTH-1:0] yAddr,
  output logic [15:0]        pixelData,
  output logic               frameStart,
  output logic               frameDone,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t                state;
  logic [HOLD_WIDTH-1:0] holdCnt;
  logic [1:0]            patLat;
  logic [15:0]           colLat;

  logic xfer, xLast, yLast;
  assign xfer  = pixelWrite & pixelReady;
  assign xLast = (xAddr == X_WIDTH'(X_MAX));
  assign yLast = (yAddr == Y_WIDTH'(Y_MAX));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      holdCnt    <= '0;
      patLat     <= '0;
      colLat     <= '0;
      pixelWrite <= 1'b0;
      xAddr      <= '0;
      yAddr      <= '0;
      frameStart <= 1'b0;
      frameDone  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frameStart <= 1'b0;
      frameDone  <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            patLat     <= patternSel;
            colLat     <= fgColour;
            xAddr      <= '0;
            yAddr      <= '0;
            pixelWrite <= 1'b1;
            frameStart <= 1'b1;
            busy       <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          // Coordinates only move on an accepted pixel; a stall holds them.
          if (xfer) begin
            if (!xLast) begin
              xAddr <= xAddr + X_WIDTH'(1);
            end else begin
              xAddr <= '0;
              if (!yLast) begin
                yAddr <= yAddr + Y_WIDTH'(1);
              end else begin
                yAddr      <= '0;
                pixelWrite <= 1'b0;
                frameDone  <= 1'b1;
                holdCnt    <= '0;
                state      <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (holdCnt == HOLD_WIDTH'(HOLDOFF - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            holdCnt <= holdCnt + HOLD_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Upper coordinate bits used by the patterns: xh = x[7:3], yh = y[8:3],
  // taken through a shift so narrower address widths still elaborate.
  logic [4:0]  xh;
  logic [5:0]  yh;
  logic [15:0] patData;
  assign xh = 5'(16'(xAddr) >> 3);
  assign yh = 6'(16'(yAddr) >> 3);

  always_comb begin
    patData = '0;
    case (patLat)
      2'd0: patData = colLat;
      2'd1: patData = {{5{xh[4]}}, {6{xh[3]}}, {5{xh[2]}}};
      2'd2: patData = (xh[1] ^ yh[1]) ? colLat : 16'h0000;
      2'd3: patData = {xh, yh, xh};
      default: patData = '0;
    endcase
  end

  // Forced to zero outside SCAN so reset and idle present a clean bus.
  assign pixelData = pixelWrite ? patData : 16'h0000;

endmodule
